// File: rtl/alu_cmd_issue.sv
// Command FIFO + valid/ready response slot wrapped around a combinational 4-bit ALU.
// Optional accumulator forwarding is enabled with `define ALU_ACC_FWD_EN.
module alu_cmd_issue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [3:0]                 cmd_a,
    input  logic [3:0]                 cmd_b,
    input  logic [2:0]                 cmd_op,
    input  logic                       cmd_use_acc,
    output logic [3:0]                 alu_a,
    output logic [3:0]                 alu_b,
    output logic [2:0]                 alu_ctrl,
    input  logic [3:0]                 alu_result,
    input  logic                       alu_carry_out,
    input  logic                       alu_zero,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [3:0]                 rsp_result,
    output logic                       rsp_carry,
    output logic                       rsp_zero,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

    rsp_state_t state_q, state_d;

    logic [3:0]    mem_a  [DEPTH];
    logic [3:0]    mem_b  [DEPTH];
    logic [2:0]    mem_op [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, issue, fifo_empty, carry_sel;

    assign fifo_empty = (count == '0);
    assign cmd_ready  = (count < (AW+1)'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign rsp_valid  = (state_q == RSP_FULL);
    assign issue      = !fifo_empty && (!rsp_valid || rsp_ready);
    assign fifo_count = count;

`ifdef ALU_ACC_FWD_EN
    logic       mem_use_acc [DEPTH];
    logic [3:0] acc;

    always_ff @(posedge clk) begin
        if (push) mem_use_acc[wr_ptr] <= cmd_use_acc;
        if (rst)        acc <= '0;
        else if (issue) acc <= alu_result;
    end

    assign alu_a = fifo_empty ? '0 : (mem_use_acc[rd_ptr] ? acc : mem_a[rd_ptr]);
`else
    logic unused_use_acc;
    assign unused_use_acc = cmd_use_acc;
    assign alu_a = fifo_empty ? '0 : mem_a[rd_ptr];
`endif

    assign alu_b    = fifo_empty ? '0 : mem_b[rd_ptr];
    assign alu_ctrl = fifo_empty ? '0 : mem_op[rd_ptr];

    // Carry is only meaningful for ADD (000) and SUB (001).
    assign carry_sel = (alu_ctrl == 3'b000 || alu_ctrl == 3'b001) ? alu_carry_out : 1'b0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]  <= cmd_a;
            mem_b[wr_ptr]  <= cmd_b;
            mem_op[wr_ptr] <= cmd_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + 1'b1;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            case ({push, issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RSP_EMPTY;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                rsp_result <= alu_result;
                rsp_carry  <= carry_sel;
                rsp_zero   <= alu_zero;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RSP_EMPTY: if (issue) state_d = RSP_FULL;
            RSP_FULL: begin
                if (issue)          state_d = RSP_FULL;
                else if (rsp_ready) state_d = RSP_EMPTY;
            end
            default: state_d = RSP_EMPTY;
        endcase
    end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue with a behavioural 4-bit ALU attached.
// Expected accumulator results follow `define ALU_ACC_FWD_EN.
module tb_alu_cmd_issue;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] cmd_op;
    logic       cmd_use_acc;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_ctrl;
    logic [3:0] alu_result;
    logic       alu_carry_out, alu_zero;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_result;
    logic       rsp_carry, rsp_zero;
    logic [2:0] fifo_count;

    logic       force_carry;
    logic [4:0] ext;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_cmd_issue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_carry_out(alu_carry_out), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .fifo_count(fifo_count)
    );

    // Behavioural ALU; force_carry lets non-arithmetic ops assert a spurious carry.
    always_comb begin
        ext = '0;
        case (alu_ctrl)
            3'b000: ext = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001: ext = {1'b0, alu_a} - {1'b0, alu_b};
            3'b010: ext = {force_carry, alu_a & alu_b};
            3'b011: ext = {force_carry, alu_a | alu_b};
            3'b100: ext = {force_carry, alu_a ^ alu_b};
            3'b101: ext = {force_carry, alu_a[2:0], 1'b0};
            3'b110: ext = {force_carry, 1'b0, alu_a[3:1]};
            default: ext = {force_carry, alu_a};
        endcase
    end
    assign alu_result    = ext[3:0];
    assign alu_carry_out = ext[4];
    assign alu_zero      = (ext[3:0] == 4'd0);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                            input logic ua, input logic [3:0] er, input logic ec,
                            input logic ez, input string name);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_use_acc = ua;
        step();
        cmd_valid = 1'b0; cmd_use_acc = 1'b0;
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== er || rsp_carry !== ec || rsp_zero !== ez) begin
            errors++;
            $display("FAIL %s: got v=%b r=%0d c=%b z=%b, expected v=1 r=%0d c=%b z=%b",
                     name, rsp_valid, rsp_result, rsp_carry, rsp_zero, er, ec, ez);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
        cmd_use_acc = 1'b0; rsp_ready = 1'b1; force_carry = 1'b0;
        step(); step();
        rst = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_result !== 4'd0 || rsp_carry !== 1'b0 ||
            rsp_zero !== 1'b0 || fifo_count !== 3'd0 || alu_a !== 4'd0 || alu_b !== 4'd0 ||
            alu_ctrl !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b v=%b r=%0d c=%b z=%b cnt=%0d a=%0d b=%0d op=%0d, expected rdy=1 others 0",
                     cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, fifo_count,
                     alu_a, alu_b, alu_ctrl);
        end
    endtask

    task automatic test_add_latency();
        cmd_valid = 1'b1; cmd_a = 4'd9; cmd_b = 4'd8; cmd_op = 3'b000;
        step();
        cmd_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || fifo_count !== 3'd1 || alu_a !== 4'd9 || alu_b !== 4'd8) begin
            errors++;
            $display("FAIL add_head: got v=%b cnt=%0d a=%0d b=%0d, expected v=0 cnt=1 a=9 b=8",
                     rsp_valid, fifo_count, alu_a, alu_b);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 4'd1 || rsp_carry !== 1'b1 || rsp_zero !== 1'b0) begin
            errors++;
            $display("FAIL add_9_8: got v=%b r=%0d c=%b z=%b, expected v=1 r=1 c=1 z=0",
                     rsp_valid, rsp_result, rsp_carry, rsp_zero);
        end
    endtask

    task automatic test_ops();
        send_one(4'd3, 4'd3, 3'b001, 1'b0, 4'd0,  1'b0, 1'b1, "sub_3_3");
        send_one(4'd2, 4'd5, 3'b001, 1'b0, 4'd13, 1'b1, 1'b0, "sub_2_5");
        force_carry = 1'b1;
        send_one(4'd5, 4'd5, 3'b100, 1'b0, 4'd0,  1'b0, 1'b1, "xor_carry_masked");
        send_one(4'd6, 4'd0, 3'b101, 1'b0, 4'd12, 1'b0, 1'b0, "shl_carry_masked");
        force_carry = 1'b0;
        send_one(4'd12, 4'd10, 3'b010, 1'b0, 4'd8, 1'b0, 1'b0, "and_12_10");
        send_one(4'd9, 4'd0, 3'b110, 1'b0, 4'd4,  1'b0, 1'b0, "shr_9");
        step();
    endtask

    task automatic test_fill_and_drain();
        rsp_ready = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_a = 4'(i + 1); cmd_b = 4'd0; cmd_op = 3'b111;
            step();
        end
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0 || fifo_count !== 3'd4 || rsp_valid !== 1'b1 || rsp_result !== 4'd1) begin
            errors++;
            $display("FAIL fill_full: got rdy=%b cnt=%0d v=%b r=%0d, expected rdy=0 cnt=4 v=1 r=1",
                     cmd_ready, fifo_count, rsp_valid, rsp_result);
        end
        cmd_valid = 1'b1; cmd_a = 4'd15;
        step(); step();
        cmd_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd4 || rsp_result !== 4'd1 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_no_push: got cnt=%0d v=%b r=%0d, expected cnt=4 v=1 r=1",
                     fifo_count, rsp_valid, rsp_result);
        end
        rsp_ready = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 4'(i + 1)) begin
                errors++;
                $display("FAIL drain_%0d: got v=%b r=%0d, expected v=1 r=%0d",
                         i, rsp_valid, rsp_result, i + 1);
            end
            step();
        end
        checks++;
        if (rsp_valid !== 1'b0 || fifo_count !== 3'd0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_end: got v=%b cnt=%0d rdy=%b, expected v=0 cnt=0 rdy=1",
                     rsp_valid, fifo_count, cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            cmd_valid = 1'b1; cmd_a = 4'(i); cmd_b = 4'd1; cmd_op = 3'b000;
            step();
            if (i > 0) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_result !== 4'(i) || fifo_count > 3'd1) begin
                    errors++;
                    $display("FAIL stream_%0d: got v=%b r=%0d cnt=%0d, expected v=1 r=%0d cnt<=1",
                             i, rsp_valid, rsp_result, fifo_count, i);
                end
            end
        end
        cmd_valid = 1'b0;
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 4'd8 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL stream_last: got v=%b r=%0d cnt=%0d, expected v=1 r=8 cnt=0",
                     rsp_valid, rsp_result, fifo_count);
        end
        step();
    endtask

    task automatic test_acc_forward();
        rsp_ready = 1'b1;
        send_one(4'd3, 4'd4, 3'b000, 1'b0, 4'd7, 1'b0, 1'b0, "acc_first");
`ifdef ALU_ACC_FWD_EN
        send_one(4'd0, 4'd2, 3'b000, 1'b1, 4'd9, 1'b0, 1'b0, "acc_chain");
`else
        send_one(4'd0, 4'd2, 3'b000, 1'b1, 4'd2, 1'b0, 1'b0, "acc_ignored");
`endif
        step();
    endtask

    task automatic test_mid_reset();
        rsp_ready = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_a = 4'(i + 5); cmd_b = 4'd0; cmd_op = 3'b111;
            step();
        end
        checks++;
        if (fifo_count !== 3'd3 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got cnt=%0d v=%b, expected cnt=3 v=1", fifo_count, rsp_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0; cmd_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || fifo_count !== 3'd0 || cmd_ready !== 1'b1 || alu_a !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b cnt=%0d rdy=%b a=%0d, expected v=0 cnt=0 rdy=1 a=0",
                     rsp_valid, fifo_count, cmd_ready, alu_a);
        end
        rsp_ready = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b0 || fifo_count !== 3'd0) begin
                errors++;
                $display("FAIL no_stale_%0d: got v=%b cnt=%0d, expected v=0 cnt=0",
                         i, rsp_valid, fifo_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_ops();
        test_fill_and_drain();
        test_back_to_back();
        test_acc_forward();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
